// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the general-register file and its read ports.
package regfile_pkg;

  // Default geometry: a 32 x 32-bit register file with two read ports.
  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NRD   = 2;

  // Address width needed to reach every register. Kept at one bit or more
  // so that degenerate depths still give a usable address port.
  function automatic int rf_aw(input int depth);
    int aw;
    aw = $clog2(depth);
    if (aw < 1) aw = 1;
    return aw;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the general-register file: a DEPTH-to-1
// mux over the flattened register array, with out-of-range and GR0 masking
// and an optional forward of the write port when it targets the same register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int AW      = rf_aw(RF_DEPTH),
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
)(
  input  logic [DEPTH*WIDTH-1:0] i_mem_flat,
  input  logic [AW-1:0]          i_ra,
  input  logic                   i_fwd_en,
  input  logic [AW-1:0]          i_wa,
  input  logic [WIDTH-1:0]       i_wd,
  output logic [WIDTH-1:0]       o_rd
);

  logic [WIDTH-1:0] w_mux;
  logic             w_hit;
  logic             w_is_r0;
  logic             w_fwd;

  // DEPTH-to-1 mux; w_hit stays low when the address names no register,
  // which only happens for non-power-of-2 depths.
  always_comb begin
    w_mux = '0;
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_ra == AW'(i)) begin
        w_mux = i_mem_flat[i*WIDTH +: WIDTH];
        w_hit = 1'b1;
      end
    end
  end

  // i_fwd_en already carries write legality and the reset suppression,
  // so only the address match is resolved here.
  assign w_is_r0 = (ZERO_R0 != 0) && (i_ra == '0);
  assign w_fwd   = (BYPASS != 0) && i_fwd_en && (i_wa == i_ra);

  // Masking takes priority over forwarding: an unreachable or hardwired-zero
  // register reads 0 even if a (necessarily ignored) write names it.
  always_comb begin
    o_rd = w_mux;
    if (!w_hit) begin
      o_rd = '0;
    end else if (w_is_r0) begin
      o_rd = '0;
    end else if (w_fwd) begin
      o_rd = i_wd;
    end
  end

endmodule

// File: rtl/gp_register_file.sv
// General-register file for the PA-RISC datapath: DEPTH x WIDTH storage with
// one synchronous write port (from writeback) and NRD combinational read
// ports (from decode). GR0 can be hardwired to zero, and a same-cycle write
// can optionally be forwarded to matching read ports.
module gp_register_file
  import regfile_pkg::*;
#(
  parameter  int WIDTH   = RF_WIDTH,
  parameter  int DEPTH   = RF_DEPTH,
  parameter  int NRD     = RF_NRD,
  parameter  int BYPASS  = 1,
  parameter  int ZERO_R0 = 1,
  localparam int AW      = rf_aw(DEPTH)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd
);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] w_mem_flat;
  logic                   w_wa_in_range;
  logic                   w_wr_legal;
  logic                   w_wr_fwd;

  // A power-of-2 depth makes every address reachable; otherwise the top
  // codes have no register behind them and writes to them are dropped.
  generate
    if (DEPTH == (1 << AW)) begin : g_full_range
      assign w_wa_in_range = 1'b1;
    end else begin : g_part_range
      assign w_wa_in_range = ({1'b0, wa} < (AW+1)'(DEPTH));
    end
  endgenerate

  // Write decode: a write lands only on a real, writable register.
  assign w_wr_legal = we && w_wa_in_range && !((ZERO_R0 != 0) && (wa == '0));

  // Forwarding is suppressed while reset is asserted, since that write is lost.
  assign w_wr_fwd = w_wr_legal && !reset;

  // Register array: reset clears everything and drops any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_legal) begin
      r_mem[wa] <= wd;
    end
  end

  // Flatten the array so each read port sees it as a single packed vector.
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign w_mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
    end
  endgenerate

  // One independent read port per requested reader.
  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      regfile_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
      ) u_port (
        .i_mem_flat (w_mem_flat),
        .i_ra       (ra[k*AW +: AW]),
        .i_fwd_en   (w_wr_fwd),
        .i_wa       (wa),
        .i_wd       (wd),
        .o_rd       (rd[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule
